// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: counter-control encoding and debounce defaults.
// Used by the control front end and by the downstream time counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        PAUSE = 2'b10
    } cnt_ctrl_e;

    localparam int DEB_CNT_SIM     = 4;
    localparam int DEB_CNT_SILICON = 500000;
    localparam int DEB_W_DEFAULT   = 20;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, stability debouncer and
// rising-edge detector producing a registered single-cycle press pulse.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_SIM,
    parameter int DEB_W   = DEB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic             press_q;

    // A differing level is accepted only after DEB_CNT consecutive differing cycles.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DEB_W'(DEB_CNT - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch control front end: debounced buttons drive a Moore FSM whose state is cnt_ctrl.
// Define STOPWATCH_LAP_EN to add the lap button and the lap_hold display-freeze register.
module stopwatch_ctrl_fsm
    import stopwatch_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_SIM,
    parameter int DEB_W   = DEB_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
`endif
    output logic [1:0] cnt_ctrl,
    output logic       lap_hold
);

`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
    logic [NUM_BTN-1:0] btn_raw;
    assign btn_raw = {btn_lap, btn_clear, btn_start_stop};
`else
    localparam int NUM_BTN = 2;
    logic [NUM_BTN-1:0] btn_raw;
    assign btn_raw = {btn_clear, btn_start_stop};
`endif

    logic [NUM_BTN-1:0] press;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CNT (DEB_CNT),
                .DEB_W   (DEB_W)
            ) u_btn_debounce (
                .clk     (clk),
                .rst     (rst),
                .btn_i   (btn_raw[gi]),
                .press_o (press[gi])
            );
        end
    endgenerate

    logic      start_stop_p;
    logic      clear_p;
    cnt_ctrl_e state_q;
    cnt_ctrl_e state_d;

    assign start_stop_p = press[0];
    assign clear_p      = press[1];

    // Clear beats start_stop in IDLE and PAUSE; clear has no effect in COUNT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!clear_p && start_stop_p) state_d = COUNT;
            COUNT:   if (start_stop_p) state_d = PAUSE;
            PAUSE: begin
                if (clear_p)           state_d = IDLE;
                else if (start_stop_p) state_d = COUNT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign cnt_ctrl = state_q;

`ifdef STOPWATCH_LAP_EN
    logic lap_p;
    logic lap_hold_q;
    logic lap_hold_d;

    assign lap_p = press[2];

    always_comb begin
        lap_hold_d = lap_hold_q;
        if (lap_p && state_q == COUNT)      lap_hold_d = ~lap_hold_q;
        else if (lap_p && state_q == PAUSE) lap_hold_d = 1'b0;
        if (state_d == IDLE)                lap_hold_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lap_hold_q <= 1'b0;
        else     lap_hold_q <= lap_hold_d;
    end

    assign lap_hold = lap_hold_q;
`else
    assign lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Scoreboard bench for stopwatch_ctrl_fsm: a sample-window reference model predicts
// {cnt_ctrl, lap_hold} for every clock; a monitor pops and compares each cycle.
module tb_stopwatch_ctrl_fsm;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_ss = 1'b0;
    logic       b_clr = 1'b0;
    logic       b_lap = 1'b0;
    logic [1:0] cnt_ctrl;
    logic       lap_hold;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    stopwatch_ctrl_fsm #(.DEB_CNT(DEB), .DEB_W(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (b_ss),
        .btn_clear      (b_clr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap        (b_lap),
`endif
        .cnt_ctrl       (cnt_ctrl),
        .lap_hold       (lap_hold)
    );

    always #5 clk = ~clk;

    // Reference model: a button level flips once the last DEB pin samples seen through
    // the 2-flop synchroniser all disagree with it; the FSM reacts two edges later.
    initial begin
        logic [DEB+1:0] hist [3];
        logic           lvl  [3];
        logic           d1   [3];
        logic           d2   [3];
        logic           act  [3];
        logic [2:0]     pins;
        logic [1:0]     st;
        logic           hold;
        for (int b = 0; b < 3; b++) begin
            hist[b] = '0; lvl[b] = 1'b0; d1[b] = 1'b0; d2[b] = 1'b0; act[b] = 1'b0;
        end
        st = 2'b00;
        hold = 1'b0;
        forever begin
            @(posedge clk);
            pins = {b_lap, b_clr, b_ss};
`ifndef STOPWATCH_LAP_EN
            pins[2] = 1'b0;
`endif
            if (rst) begin
                for (int b = 0; b < 3; b++) begin
                    hist[b] = '0; lvl[b] = 1'b0; d1[b] = 1'b0; d2[b] = 1'b0;
                end
                st = 2'b00;
                hold = 1'b0;
            end else begin
                for (int b = 0; b < 3; b++) begin
                    hist[b] = {hist[b][DEB:0], pins[b]};
                    act[b]  = d2[b];
                    d2[b]   = d1[b];
                    d1[b]   = 1'b0;
                    if (hist[b][DEB+1:2] == {DEB{~lvl[b]}}) begin
                        lvl[b] = ~lvl[b];
                        d1[b]  = lvl[b];
                    end
                end
                case (st)
                    2'b00: if (!act[1] && act[0]) st = 2'b01;
                    2'b01: begin
                        if (act[2]) hold = ~hold;
                        if (act[0]) st = 2'b10;
                    end
                    2'b10: begin
                        if (act[2]) hold = 1'b0;
                        if (act[1])      st = 2'b00;
                        else if (act[0]) st = 2'b01;
                    end
                    default: st = 2'b00;
                endcase
                if (st == 2'b00) hold = 1'b0;
            end
            exp_q.push_back({st, hold});
        end
    end

    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({cnt_ctrl, lap_hold} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got cnt_ctrl=%b lap_hold=%b expected cnt_ctrl=%b lap_hold=%b",
                             $time, cnt_ctrl, lap_hold, e[2:1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got {cnt_ctrl,lap_hold}=%b expected %b", nm, $time, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [2:0] v);
        b_ss  = v[0];
        b_clr = v[1];
        b_lap = v[2];
    endtask

    task automatic press(input logic [2:0] v, input int hold_cyc, input int gap);
        set_btns(v);
        tick(hold_cyc);
        set_btns(3'b000);
        tick(gap);
        $display("txn btns=%b hold=%0d cnt_ctrl=%b lap_hold=%b", v, hold_cyc, cnt_ctrl, lap_hold);
    endtask

    initial begin
        // Reset for 3 cycles, then idle.
        tick(3);
        chk("reset_state", {cnt_ctrl, lap_hold}, 3'b000);
        rst = 1'b0;
        tick(100);
        chk("idle_100", {cnt_ctrl, lap_hold}, 3'b000);

        // Bounce faster than the debounce window is rejected.
        for (int i = 0; i < 10; i++) begin
            b_ss = ~b_ss;
            tick(2);
        end
        b_ss = 1'b0;
        tick(15);
        chk("bounce_reject", {cnt_ctrl, lap_hold}, 3'b000);

        // Latency: first sampling edge is edge 0, change lands on edge 7.
        b_ss = 1'b1;
        tick(7);
        chk("latency_edge6", {cnt_ctrl, lap_hold}, 3'b000);
        tick(1);
        chk("latency_edge7", {cnt_ctrl, lap_hold}, 3'b010);
        tick(2);
        b_ss = 1'b0;
        tick(15);
        press(3'b001, 10, 15);
        chk("count_to_pause", {cnt_ctrl, lap_hold}, 3'b100);
        press(3'b001, 10, 15);
        chk("pause_to_count", {cnt_ctrl, lap_hold}, 3'b010);

        // Clear semantics and simultaneous presses.
        press(3'b010, 8, 15);
        chk("clear_in_count", {cnt_ctrl, lap_hold}, 3'b010);
        press(3'b001, 8, 15);
        press(3'b010, 8, 15);
        chk("clear_in_pause", {cnt_ctrl, lap_hold}, 3'b000);
        press(3'b001, 8, 15);
        press(3'b001, 8, 15);
        press(3'b011, 8, 15);
        chk("both_in_pause", {cnt_ctrl, lap_hold}, 3'b000);
        press(3'b011, 8, 15);
        chk("both_in_idle", {cnt_ctrl, lap_hold}, 3'b000);

        // Async reset during COUNT with start_stop held through release.
        press(3'b001, 8, 15);
        chk("count_again", {cnt_ctrl, lap_hold}, 3'b010);
        b_ss = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        chk("async_reset", {cnt_ctrl, lap_hold}, 3'b000);
        tick(2);
        rst = 1'b0;
        tick(7);
        chk("post_reset_edge6", {cnt_ctrl, lap_hold}, 3'b000);
        tick(1);
        chk("post_reset_edge7", {cnt_ctrl, lap_hold}, 3'b010);
        b_ss = 1'b0;
        tick(15);

`ifdef STOPWATCH_LAP_EN
        press(3'b100, 8, 15);
        chk("lap_set", {cnt_ctrl, lap_hold}, 3'b011);
        press(3'b100, 8, 15);
        chk("lap_toggle_off", {cnt_ctrl, lap_hold}, 3'b010);
        press(3'b100, 8, 15);
        press(3'b001, 8, 15);
        chk("lap_kept_in_pause", {cnt_ctrl, lap_hold}, 3'b101);
        press(3'b010, 8, 15);
        chk("lap_cleared_idle", {cnt_ctrl, lap_hold}, 3'b000);
        press(3'b100, 8, 15);
        chk("lap_ignored_idle", {cnt_ctrl, lap_hold}, 3'b000);
`endif

        // Randomised button activity, including short bounces and async resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                #1;
                chk("rand_async_reset", {cnt_ctrl, lap_hold}, 3'b000);
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
            press(3'($urandom_range(0, 7)), $urandom_range(1, 10), $urandom_range(1, 10));
        end

        tick(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
